// File: rtl/pipeline_sequencer_pkg.sv
// Shared definitions for the pipeline sequencer: FSM state encodings and widths.
// Encodings are visible on o_state, so their values are fixed at 0..4.
package pipeline_sequencer_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_STEP  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/pipeline_sequencer_hazard_detect.sv
// Load-use hazard compare between the load in EX and the source registers in ID.
// Latency: combinational. Backpressure: none, the stall output is itself the backpressure.
module hazard_detect #(
    parameter int NB_REG = 5
) (
    input  logic              idex_mem_read,
    input  logic [NB_REG-1:0] idex_rt,
    input  logic [NB_REG-1:0] ifid_rs,
    input  logic [NB_REG-1:0] ifid_rt,
    output logic              stall
);

    // r0 is hardwired zero, so a load into it never creates a dependency.
    assign stall = idex_mem_read && (idex_rt != '0) &&
                   ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

endmodule

// File: rtl/pipeline_sequencer.sv
// Debug-controlled sequencer for the 5-stage pipeline; drives PC/IF-ID/ID-EX enables and flushes.
// Latency: outputs combinational from state and hazards; state changes one cycle after its cause.
// Backpressure: load-use stall holds PC and IF/ID; PIPE_CYCLE_COUNT_EN adds the enabled-cycle counter.
module pipeline_sequencer
    import pipeline_sequencer_pkg::*;
#(
    parameter int NB_REG       = 5,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_dbg_run,
    input  logic              i_dbg_step,
    input  logic              i_halt_id,
    input  logic              i_idex_mem_read,
    input  logic [NB_REG-1:0] i_idex_rt,
    input  logic [NB_REG-1:0] i_ifid_rs,
    input  logic [NB_REG-1:0] i_ifid_rt,
    input  logic              i_branch_taken,
    output logic              o_pc_en,
    output logic              o_ifid_en,
    output logic              o_ifid_flush,
    output logic              o_idex_flush,
    output logic              o_pipe_en,
    output logic [STATE_W-1:0] o_state,
    output logic              o_done,
    output logic [CNT_W-1:0]  o_cycle_count
);

    localparam int DCNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    state_t            state;
    logic [DCNT_W-1:0] drain_cnt;
    logic              step_q;
    logic              step_edge;
    logic              stall;

    hazard_detect #(.NB_REG(NB_REG)) u_hazard (
        .idex_mem_read (i_idex_mem_read),
        .idex_rt       (i_idex_rt),
        .ifid_rs       (i_ifid_rs),
        .ifid_rt       (i_ifid_rt),
        .stall         (stall)
    );

    assign step_edge = i_dbg_step & ~step_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            drain_cnt <= '0;
            step_q    <= 1'b0;
        end else begin
            step_q <= i_dbg_step;
            case (state)
                ST_IDLE: begin
                    if (i_dbg_run)
                        state <= ST_RUN;
                    else if (step_edge)
                        state <= ST_STEP;
                end
                ST_RUN: begin
                    if (i_halt_id && !stall) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= DCNT_W'(DRAIN_CYCLES - 1);
                    end
                end
                ST_STEP: begin
                    // A stalled step is still consumed; the next step retries the held instruction.
                    if (i_halt_id && !stall) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= DCNT_W'(DRAIN_CYCLES - 1);
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == '0)
                        state <= ST_DONE;
                    else
                        drain_cnt <= drain_cnt - DCNT_W'(1);
                end
                ST_DONE: state <= ST_DONE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        o_pc_en      = 1'b0;
        o_ifid_en    = 1'b0;
        o_ifid_flush = 1'b0;
        o_idex_flush = 1'b0;
        o_pipe_en    = 1'b0;
        if (!i_rst) begin
            case (state)
                ST_RUN, ST_STEP: begin
                    o_pipe_en = 1'b1;
                    if (stall) begin
                        o_idex_flush = 1'b1;
                    end else begin
                        o_pc_en      = 1'b1;
                        o_ifid_en    = 1'b1;
                        o_ifid_flush = i_branch_taken;
                    end
                end
                ST_DRAIN: begin
                    // PC frozen at HALT; NOPs are fed in behind it while older work retires.
                    o_ifid_en    = 1'b1;
                    o_ifid_flush = 1'b1;
                    o_pipe_en    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_state = state;
    assign o_done  = (state == ST_DONE);

`ifdef PIPE_CYCLE_COUNT_EN
    logic [CNT_W-1:0] cycle_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            cycle_cnt <= '0;
        else if (o_pipe_en)
            cycle_cnt <= cycle_cnt + CNT_W'(1);
    end

    assign o_cycle_count = cycle_cnt;
`else
    assign o_cycle_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer: reset, stepping, stalls, branch flush, drain and reset-in-drain.
module tb_pipeline_sequencer;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_dbg_run;
    logic        i_dbg_step;
    logic        i_halt_id;
    logic        i_idex_mem_read;
    logic [4:0]  i_idex_rt;
    logic [4:0]  i_ifid_rs;
    logic [4:0]  i_ifid_rt;
    logic        i_branch_taken;
    logic        o_pc_en;
    logic        o_ifid_en;
    logic        o_ifid_flush;
    logic        o_idex_flush;
    logic        o_pipe_en;
    logic [2:0]  o_state;
    logic        o_done;
    logic [31:0] o_cycle_count;

    int n_total = 0;
    int n_bad   = 0;

    localparam logic [31:0] S_IDLE  = 32'd0;
    localparam logic [31:0] S_RUN   = 32'd1;
    localparam logic [31:0] S_DRAIN = 32'd3;
    localparam logic [31:0] S_DONE  = 32'd4;

`ifdef PIPE_CYCLE_COUNT_EN
    localparam logic [31:0] EXP_CNT10 = 32'd10;
`else
    localparam logic [31:0] EXP_CNT10 = 32'd0;
`endif

    always #5 i_clk = ~i_clk;

    pipeline_sequencer dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_dbg_run       (i_dbg_run),
        .i_dbg_step      (i_dbg_step),
        .i_halt_id       (i_halt_id),
        .i_idex_mem_read (i_idex_mem_read),
        .i_idex_rt       (i_idex_rt),
        .i_ifid_rs       (i_ifid_rs),
        .i_ifid_rt       (i_ifid_rt),
        .i_branch_taken  (i_branch_taken),
        .o_pc_en         (o_pc_en),
        .o_ifid_en       (o_ifid_en),
        .o_ifid_flush    (o_ifid_flush),
        .o_idex_flush    (o_idex_flush),
        .o_pipe_en       (o_pipe_en),
        .o_state         (o_state),
        .o_done          (o_done),
        .o_cycle_count   (o_cycle_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle 1ns after the edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
    endtask

    int pc_cycles;

    initial begin
        i_rst = 1'b1;
        i_dbg_run = 1'b0;
        i_dbg_step = 1'b0;
        i_halt_id = 1'b0;
        i_idex_mem_read = 1'b0;
        i_idex_rt = 5'd0;
        i_ifid_rs = 5'd0;
        i_ifid_rt = 5'd0;
        i_branch_taken = 1'b0;

        // 1: reset then idle
        do_reset();
        repeat (5) tick();
        check_eq("idle_state",   32'(o_state),   S_IDLE);
        check_eq("idle_pc_en",   32'(o_pc_en),   32'd0);
        check_eq("idle_ifid_en", 32'(o_ifid_en), 32'd0);
        check_eq("idle_pipe_en", 32'(o_pipe_en), 32'd0);
        check_eq("idle_done",    32'(o_done),    32'd0);
        check_eq("rst_cycle_cnt", o_cycle_count, 32'd0);

        // 2: two step pulses, each 3 cycles wide, each yields exactly one enabled cycle
        for (int p = 0; p < 2; p++) begin
            pc_cycles = 0;
            for (int i = 0; i < 6; i++) begin
                i_dbg_step = (i < 3);
                #1;
                pc_cycles += int'(o_pc_en);
                tick();
            end
            check_eq(p == 0 ? "step1_pc_cycles" : "step2_pc_cycles", 32'(pc_cycles), 32'd1);
            check_eq(p == 0 ? "step1_back_idle" : "step2_back_idle", 32'(o_state), S_IDLE);
        end

        // 10 run cycles for the counter
        do_reset();
        check_eq("cnt_after_rst", o_cycle_count, 32'd0);
        i_dbg_run = 1'b1;
        tick();
        check_eq("run_state", 32'(o_state), S_RUN);
        repeat (10) tick();
        check_eq("cnt_10_run", o_cycle_count, EXP_CNT10);

        // 3: load-use stall and r0 exemption
        i_idex_mem_read = 1'b1; i_idex_rt = 5'd5; i_ifid_rs = 5'd5; i_ifid_rt = 5'd7;
        #1;
        check_eq("stall_pc_en",      32'(o_pc_en),      32'd0);
        check_eq("stall_ifid_en",    32'(o_ifid_en),    32'd0);
        check_eq("stall_idex_flush", 32'(o_idex_flush), 32'd1);
        check_eq("stall_pipe_en",    32'(o_pipe_en),    32'd1);
        i_ifid_rs = 5'd2; i_ifid_rt = 5'd5;
        #1;
        check_eq("stall_rt_match",   32'(o_idex_flush), 32'd1);
        i_idex_rt = 5'd0; i_ifid_rs = 5'd0; i_ifid_rt = 5'd0;
        #1;
        check_eq("r0_no_stall_pc",   32'(o_pc_en),      32'd1);
        check_eq("r0_no_stall_fl",   32'(o_idex_flush), 32'd0);

        // 4: taken branch, then branch masked by stall
        i_idex_mem_read = 1'b0; i_branch_taken = 1'b1;
        #1;
        check_eq("br_ifid_flush", 32'(o_ifid_flush), 32'd1);
        check_eq("br_pc_en",      32'(o_pc_en),      32'd1);
        i_idex_mem_read = 1'b1; i_idex_rt = 5'd5; i_ifid_rs = 5'd5;
        #1;
        check_eq("br_stall_ifid_flush", 32'(o_ifid_flush), 32'd0);
        check_eq("br_stall_pc_en",      32'(o_pc_en),      32'd0);
        check_eq("br_stall_idex_flush", 32'(o_idex_flush), 32'd1);
        // HALT is ignored while stalled
        i_halt_id = 1'b1;
        tick();
        check_eq("halt_stalled_stays_run", 32'(o_state), S_RUN);

        // 5: HALT unstalled -> 3 drain cycles -> DONE
        i_idex_mem_read = 1'b0; i_branch_taken = 1'b0; i_idex_rt = 5'd0; i_ifid_rs = 5'd0;
        tick();
        i_halt_id = 1'b0;
        check_eq("drain_entry", 32'(o_state), S_DRAIN);
        check_eq("drain_ifid_flush", 32'(o_ifid_flush), 32'd1);
        check_eq("drain_ifid_en",    32'(o_ifid_en),    32'd1);
        pc_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            pc_cycles += int'(o_pc_en);
            tick();
        end
        check_eq("drain_pc_en_cycles", 32'(pc_cycles), 32'd0);
        check_eq("done_state", 32'(o_state), S_DONE);
        check_eq("done_flag",  32'(o_done),  32'd1);
        i_dbg_run = 1'b0; tick();
        i_dbg_run = 1'b1; tick();
        i_dbg_run = 1'b0; tick();
        check_eq("done_sticky",  32'(o_state),   S_DONE);
        check_eq("done_pipe_en", 32'(o_pipe_en), 32'd0);

        // 6: reset in the middle of DRAIN
        do_reset();
        i_dbg_run = 1'b1;
        tick();
        i_halt_id = 1'b1;
        tick();
        i_halt_id = 1'b0;
        i_dbg_run = 1'b0;
        tick();
        check_eq("mid_drain_state", 32'(o_state), S_DRAIN);
        i_rst = 1'b1;
        #1;
        check_eq("rst_gates_ifid_en",    32'(o_ifid_en),    32'd0);
        check_eq("rst_gates_ifid_flush", 32'(o_ifid_flush), 32'd0);
        check_eq("rst_gates_pipe_en",    32'(o_pipe_en),    32'd0);
        tick();
        i_rst = 1'b0;
        check_eq("rst_drain_idle", 32'(o_state), S_IDLE);
        check_eq("rst_drain_done", 32'(o_done),  32'd0);
        check_eq("rst_drain_cnt",  o_cycle_count, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
